seg_595_scan_n: RTL and testbench



---
 rtl/seg595_pkg.sv | 26 ++
 rtl/seg7_hex_decode.sv | 14 +
 rtl/seg_595_scan_n.sv | 202 ++++++++++++++++++++
 tb/tb_seg_595_scan_n.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg595_pkg.sv
// Shared types, glyph table and sizing helpers
// for the multiplexed 74HC595 seven-segment driver.
package seg595_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_HOLD
  } state_e;

  localparam int SEG_W = 8;

  // gfedcba glyphs, index 15 first
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int shift_len(int digits);
    return SEG_W + digits;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex digit to {dp,g..a} segment byte, 1 = lit.
// Blank darkens the whole digit including dp.
module seg7_hex_decode
  import seg595_pkg::*;
(
  input  logic [3:0]       code_i,
  input  logic             dp_i,
  input  logic             blank_i,
  output logic [SEG_W-1:0] seg_o
);

  assign seg_o = blank_i ? '0 : {dp_i, HEX_SEG[code_i]};

endmodule

// File: rtl/seg_595_scan_n.sv
// N-digit 595 scan driver with double-buffered frames,
// per-digit blanking and 16-level OE PWM brightness.
module seg_595_scan_n
  import seg595_pkg::*;
#(
  parameter int DIGITS         = 6,
  parameter int CLK_DIV        = 2,
  parameter int SLOT_CYCLES    = 3125,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [4*DIGITS-1:0]   upd_hex,
  input  logic [DIGITS-1:0]     upd_dp,
  input  logic [DIGITS-1:0]     upd_blank,
  input  logic [3:0]            brightness,
  output logic                  ds,
  output logic                  shcp,
  output logic                  stcp,
  output logic                  oe
);

  localparam int SW  = shift_len(DIGITS);
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW  = $clog2(SW + 1);
  localparam int PW  = $clog2(2 * CLK_DIV + 1);
  localparam int SCW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  localparam logic [SEG_W-1:0] SEG_INV =
    (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [DIGITS-1:0] SEL_INV =
    (SEL_ACTIVE_LOW != 0) ? '1 : '0;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [PW-1:0]       ph_q, ph_d;
  logic [3:0]          slot_q, slot_d;
  logic [SCW-1:0]      scnt_q, scnt_d;
  logic [SW-1:0]       sh_q, sh_d;
  logic                rdy_q, rdy_d;

  logic [4*DIGITS-1:0] p_hex_q, p_hex_d;
  logic [DIGITS-1:0]   p_dp_q, p_dp_d;
  logic [DIGITS-1:0]   p_blk_q, p_blk_d;
  logic [4*DIGITS-1:0] a_hex_q, a_hex_d;
  logic [DIGITS-1:0]   a_dp_q, a_dp_d;
  logic [DIGITS-1:0]   a_blk_q, a_blk_d;

  logic                at_first;
  logic [4*DIGITS-1:0] src_hex;
  logic [DIGITS-1:0]   src_dp;
  logic [DIGITS-1:0]   src_blk;
  logic [3:0]          cur_hex;
  logic [SEG_W-1:0]    cur_seg;
  logic [DIGITS-1:0]   cur_sel;
  logic [SW-1:0]       word;
  logic                ph_end;

  assign at_first = (idx_q == '0);

  // Digit 0 reads the pending frame so the frame swap shows immediately
  assign src_hex = at_first ? p_hex_q : a_hex_q;
  assign src_dp  = at_first ? p_dp_q  : a_dp_q;
  assign src_blk = at_first ? p_blk_q : a_blk_q;
  assign cur_hex = src_hex[int'(idx_q)*4 +: 4];
  assign cur_sel = DIGITS'(1) << idx_q;

  seg7_hex_decode u_dec (
    .code_i  (cur_hex),
    .dp_i    (src_dp[idx_q]),
    .blank_i (src_blk[idx_q]),
    .seg_o   (cur_seg)
  );

  assign word   = {cur_seg ^ SEG_INV, cur_sel ^ SEL_INV};
  assign ph_end = (ph_q == PW'(2 * CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    slot_d  = slot_q;
    scnt_d  = scnt_q;
    sh_d    = sh_q;
    rdy_d   = rdy_q;
    p_hex_d = p_hex_q;
    p_dp_d  = p_dp_q;
    p_blk_d = p_blk_q;
    a_hex_d = a_hex_q;
    a_dp_d  = a_dp_q;
    a_blk_d = a_blk_q;

    unique case (state_q)
      ST_LOAD: begin
        sh_d    = word;
        ph_d    = '0;
        bit_d   = '0;
        state_d = ST_SHIFT;
        if (at_first) begin
          a_hex_d = p_hex_q;
          a_dp_d  = p_dp_q;
          a_blk_d = p_blk_q;
        end
      end
      ST_SHIFT: begin
        if (ph_end) begin
          ph_d = '0;
          if (bit_q == BW'(SW - 1)) begin
            state_d = ST_LATCH;
          end else begin
            bit_d = bit_q + 1'b1;
            sh_d  = {sh_q[SW-2:0], 1'b0};
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ST_LATCH: begin
        if (ph_end) begin
          ph_d    = '0;
          slot_d  = '0;
          scnt_d  = '0;
          state_d = ST_HOLD;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (scnt_q == SCW'(SLOT_CYCLES - 1)) begin
          scnt_d = '0;
          if (slot_q == 4'd15) begin
            state_d = ST_LOAD;
            idx_d   = (idx_q == IW'(DIGITS - 1)) ?
                      '0 : idx_q + 1'b1;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
    endcase

    if (upd_valid && rdy_q) begin
      p_hex_d = upd_hex;
      p_dp_d  = upd_dp;
      p_blk_d = upd_blank;
      rdy_d   = 1'b0;
    end else if (state_q == ST_LOAD && at_first) begin
      rdy_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      bit_q   <= '0;
      ph_q    <= '0;
      slot_q  <= '0;
      scnt_q  <= '0;
      sh_q    <= '0;
      rdy_q   <= 1'b0;
      p_hex_q <= '0;
      p_dp_q  <= '0;
      p_blk_q <= '1;
      a_hex_q <= '0;
      a_dp_q  <= '0;
      a_blk_q <= '1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      slot_q  <= slot_d;
      scnt_q  <= scnt_d;
      sh_q    <= sh_d;
      rdy_q   <= rdy_d;
      p_hex_q <= p_hex_d;
      p_dp_q  <= p_dp_d;
      p_blk_q <= p_blk_d;
      a_hex_q <= a_hex_d;
      a_dp_q  <= a_dp_d;
      a_blk_q <= a_blk_d;
    end
  end

  assign upd_ready = rdy_q;
  assign ds        = sh_q[SW-1];
  assign shcp      = (state_q == ST_SHIFT) &&
                     (ph_q >= PW'(CLK_DIV));
  assign stcp      = (state_q == ST_LATCH) &&
                     (ph_q >= PW'(CLK_DIV));
  assign oe        = !((state_q == ST_HOLD) &&
                       (slot_q <= brightness));

endmodule

// File: tb/tb_seg_595_scan_n.sv
// Directed bench for seg_595_scan_n: shift words,
// timing, handshake, PWM, blanking and mid-shift reset.
module tb_seg_595_scan_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid;
  logic        ready;
  logic [23:0] hex;
  logic [5:0]  dp;
  logic [5:0]  blank;
  logic [3:0]  bri;
  logic        ds, shcp, stcp, oe;

  always #5 clk = ~clk;

  seg_595_scan_n #(
    .DIGITS         (6),
    .CLK_DIV        (1),
    .SLOT_CYCLES    (4),
    .SEG_ACTIVE_LOW (1),
    .SEL_ACTIVE_LOW (1)
  ) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .upd_valid  (valid),
    .upd_ready  (ready),
    .upd_hex    (hex),
    .upd_dp     (dp),
    .upd_blank  (blank),
    .brightness (bri),
    .ds         (ds),
    .shcp       (shcp),
    .stcp       (stcp),
    .oe         (oe)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // words per digit 0..5, hand-decoded and inverted
  localparam logic [5:0][13:0] DARK = {
    {8'hFF, 6'b011111}, {8'hFF, 6'b101111},
    {8'hFF, 6'b110111}, {8'hFF, 6'b111011},
    {8'hFF, 6'b111101}, {8'hFF, 6'b111110}
  };
  localparam logic [5:0][13:0] F1 = {
    {8'hC0, 6'b011111}, {8'hF9, 6'b101111},
    {8'hA4, 6'b110111}, {8'h30, 6'b111011},
    {8'h99, 6'b111101}, {8'h92, 6'b111110}
  };
  localparam logic [5:0][13:0] F2 = {
    {8'h82, 6'b011111}, {8'hF8, 6'b101111},
    {8'h80, 6'b110111}, {8'h90, 6'b111011},
    {8'h88, 6'b111101}, {8'h83, 6'b111110}
  };
  localparam logic [5:0][13:0] F3 = {
    {8'hFF, 6'b011111}, {8'h86, 6'b101111},
    {8'hA1, 6'b110111}, {8'hC6, 6'b111011},
    {8'hF9, 6'b111101}, {8'h40, 6'b111110}
  };

  logic [13:0] acc;
  logic        p_sh, p_st;
  int          oecnt;
  int          ghost = 0;
  int          cyc   = 0;
  int          first_st = -1;
  int          first_oe = -1;
  logic [13:0] wq[$];
  int          oq[$];

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      acc   = '0;
      p_sh  = 1'b0;
      p_st  = 1'b0;
      oecnt = 0;
    end else begin
      if (shcp && !p_sh) acc = {acc[12:0], ds};
      if (stcp && !p_st) begin
        wq.push_back(acc);
        oq.push_back(oecnt);
        oecnt = 0;
      end
      if (!oe) oecnt++;
      if (!oe && (shcp || stcp)) ghost++;
      if (first_st < 0 && stcp) first_st = cyc;
      if (first_oe < 0 && !oe) first_oe = cyc;
      p_sh = shcp;
      p_st = stcp;
    end
  end

  task automatic flush();
    wq.delete();
    oq.delete();
  endtask

  task automatic wait_words(string tag, int n);
    int t = 0;
    while (wq.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_words"}, 32'(wq.size() >= n), 1);
  endtask

  task automatic wait_ready(string tag);
    int t = 0;
    while (!ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_ready"}, 32'(ready), 1);
  endtask

  task automatic check_frame(string tag,
                             logic [5:0][13:0] e);
    for (int i = 0; i < 6; i++)
      if (i < wq.size())
        chk($sformatf("%s_d%0d", tag, i), 32'(wq[i]),
            32'(e[i]));
  endtask

  task automatic check_oe(string tag, int lo, int hi,
                          int exp);
    for (int i = lo; i <= hi; i++)
      if (i < oq.size())
        chk($sformatf("%s_oe%0d", tag, i), oq[i], exp);
  endtask

  task automatic check_rst_outs(string tag);
    chk({tag, "_ds"},    32'(ds),    0);
    chk({tag, "_shcp"},  32'(shcp),  0);
    chk({tag, "_stcp"},  32'(stcp),  0);
    chk({tag, "_oe"},    32'(oe),    1);
    chk({tag, "_ready"}, 32'(ready), 0);
  endtask

  initial begin
    valid = 1'b0;
    hex   = '0;
    dp    = '0;
    blank = '0;
    bri   = 4'd15;
    repeat (3) @(negedge clk);
    check_rst_outs("rst");

    rst = 1'b0;
    flush();
    @(negedge clk);
    chk("ready_after_rst", 32'(ready), 1);
    wait_words("dark", 6);
    check_frame("dark", DARK);
    chk("first_stcp_cyc", first_st, 30);
    chk("first_oe_cyc", first_oe, 31);

    hex   = 24'h012345;
    dp    = 6'b000100;
    blank = 6'b000000;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk("f1_ready_drop", 32'(ready), 0);
    wait_ready("f1");
    flush();
    wait_words("f1", 6);
    check_frame("f1", F1);
    check_oe("f1", 1, 5, 64);

    bri = 4'd3;
    flush();
    wait_words("b3", 7);
    check_oe("b3", 1, 6, 16);

    bri   = 4'd15;
    hex   = 24'h6789AB;
    dp    = 6'b000000;
    blank = 6'b000000;
    valid = 1'b1;
    wait_ready("f2");
    @(negedge clk);
    hex   = 24'h8EDC10;
    dp    = 6'b100001;
    blank = 6'b100000;
    chk("f2_ready_drop", 32'(ready), 0);
    wait_ready("f3");
    flush();
    @(negedge clk);
    valid = 1'b0;
    chk("f3_accept_next", 32'(ready), 0);
    wait_words("f2", 6);
    check_frame("f2", F2);
    wait_ready("f3b");
    flush();
    wait_words("f3", 6);
    check_frame("f3", F3);

    begin
      int t = 0;
      while (oe && t < 3000) begin
        @(negedge clk);
        t++;
      end
      while (!oe && t < 3000) begin
        @(negedge clk);
        t++;
      end
      chk("hold_exit_seen", 32'(t < 3000), 1);
    end
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_rst_outs("midrst");
    rst = 1'b0;
    flush();
    wait_words("post", 6);
    check_frame("post", DARK);
    chk("ghost_oe", ghost, 0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
